mcp3202_spi_responder: RTL and testbench

MCP3202_SPI_RESPONDER -- requirements
Module: mcp3202_spi_responder

---
 rtl/mcp3202_spi_responder.sv | 150 +++++++++++++++
 tb/tb_mcp3202_spi_responder.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/mcp3202_spi_responder.sv
// mcp3202_spi_responder: emulates an MCP3202 ADC SPI slave (mode 0,0), serving codes loaded over AXI-Stream.
// All SPI pins are resynchronised into clk; miso is a registered output driven from sck falls.
module mcp3202_spi_responder #(
    parameter int SYNC_STAGES = 2,
    parameter int LSB_REPEAT  = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cs,
    input  logic        sck,
    input  logic        mosi,
    output logic        miso,
    output logic        miso_oe,
    input  logic [15:0] s_axis_adc_tdata,
    input  logic        s_axis_adc_tvalid,
    output logic        s_axis_adc_tready,
    output logic        frame_done,
    output logic        frame_err
);

    typedef enum logic [3:0] {
        IDLE, WAIT_START, GET_SGL, GET_ODD, GET_MSBF, NULL_BIT, DATA_MSB, DATA_LSB, DONE
    } state_t;

    state_t state;
    logic [SYNC_STAGES-1:0] cs_sr, sck_sr, mosi_sr;
    logic        cs_d, sck_d;
    logic        cs_s, sck_s, mosi_s;
    logic        cs_fall, cs_rise, sck_rise, sck_fall;
    logic [11:0] ch0_q, ch1_q, shreg, snap, sat01, sat10;
    logic [12:0] d01, d10;
    logic [3:0]  cnt;
    logic        sgl_q, msbf_q;
    logic        unused;

    assign unused = ^s_axis_adc_tdata[15:13];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cs_sr   <= '1;
            sck_sr  <= '0;
            mosi_sr <= '0;
            cs_d    <= 1'b1;
            sck_d   <= 1'b0;
        end else begin
            cs_sr   <= {cs_sr[SYNC_STAGES-2:0], cs};
            sck_sr  <= {sck_sr[SYNC_STAGES-2:0], sck};
            mosi_sr <= {mosi_sr[SYNC_STAGES-2:0], mosi};
            cs_d    <= cs_s;
            sck_d   <= sck_s;
        end
    end

    assign cs_s     = cs_sr[SYNC_STAGES-1];
    assign sck_s    = sck_sr[SYNC_STAGES-1];
    assign mosi_s   = mosi_sr[SYNC_STAGES-1];
    assign cs_fall  = cs_d & ~cs_s;
    assign cs_rise  = ~cs_d & cs_s;
    assign sck_rise = ~cs_s & sck_s & ~sck_d;
    assign sck_fall = ~cs_s & ~sck_s & sck_d;

    // Pseudo-differential results clamp at zero rather than wrapping.
    assign d01   = {1'b0, ch0_q} - {1'b0, ch1_q};
    assign d10   = {1'b0, ch1_q} - {1'b0, ch0_q};
    assign sat01 = d01[12] ? 12'd0 : d01[11:0];
    assign sat10 = d10[12] ? 12'd0 : d10[11:0];
    assign snap  = sgl_q ? (mosi_s ? ch1_q : ch0_q) : (mosi_s ? sat10 : sat01);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ch0_q             <= '0;
            ch1_q             <= '0;
            s_axis_adc_tready <= 1'b0;
        end else begin
            s_axis_adc_tready <= 1'b1;
            if (s_axis_adc_tvalid && s_axis_adc_tready) begin
                if (s_axis_adc_tdata[12]) ch1_q <= s_axis_adc_tdata[11:0];
                else                      ch0_q <= s_axis_adc_tdata[11:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            shreg      <= '0;
            cnt        <= '0;
            sgl_q      <= 1'b0;
            msbf_q     <= 1'b0;
            miso       <= 1'b0;
            miso_oe    <= 1'b0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
            if (cs_rise) begin
                state     <= IDLE;
                miso      <= 1'b0;
                miso_oe   <= 1'b0;
                frame_err <= (state == NULL_BIT) || (state == DATA_MSB) || (state == DATA_LSB);
            end else begin
                case (state)
                    IDLE:       if (cs_fall) state <= WAIT_START;
                    WAIT_START: if (sck_rise && mosi_s) state <= GET_SGL;
                    GET_SGL: if (sck_rise) begin
                        sgl_q <= mosi_s;
                        state <= GET_ODD;
                    end
                    GET_ODD: if (sck_rise) begin
                        shreg <= snap;
                        state <= GET_MSBF;
                    end
                    GET_MSBF: if (sck_rise) begin
                        msbf_q <= mosi_s;
                        state  <= NULL_BIT;
                    end
                    NULL_BIT: if (sck_fall) begin
                        miso    <= 1'b0;
                        miso_oe <= 1'b1;
                        cnt     <= 4'd11;
                        state   <= DATA_MSB;
                    end
                    DATA_MSB: if (sck_fall) begin
                        miso <= shreg[cnt];
                        if (cnt == 4'd0) begin
                            cnt   <= 4'd1;
                            state <= (msbf_q || LSB_REPEAT == 0) ? DONE : DATA_LSB;
                        end else begin
                            cnt <= cnt - 4'd1;
                        end
                    end
                    DATA_LSB: if (sck_fall) begin
                        miso <= shreg[cnt];
                        cnt  <= cnt + 4'd1;
                        if (cnt == 4'd11) state <= DONE;
                    end
                    // miso_oe doubles as "final fall not yet seen" so later edges are ignored.
                    DONE: if (sck_fall && miso_oe) begin
                        miso       <= 1'b0;
                        miso_oe    <= 1'b0;
                        frame_done <= 1'b1;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mcp3202_spi_responder.sv
// tb_mcp3202_spi_responder: directed SPI frames; expected miso bits are queued and checked by a monitor on sck rises.
module tb_mcp3202_spi_responder;

    localparam int CLK_HALF = 5;
    localparam int SCK_HALF = 50;

    logic        clk = 1'b0;
    logic        rst_n, cs, sck, mosi;
    logic        miso, miso_oe;
    logic [15:0] tdata;
    logic        tvalid, tready;
    logic        frame_done, frame_err;

    int vectors = 0;
    int miscompares = 0;
    int done_cnt = 0;
    int err_cnt = 0;
    logic exp_q[$];

    mcp3202_spi_responder dut (
        .clk(clk), .rst_n(rst_n), .cs(cs), .sck(sck), .mosi(mosi),
        .miso(miso), .miso_oe(miso_oe),
        .s_axis_adc_tdata(tdata), .s_axis_adc_tvalid(tvalid), .s_axis_adc_tready(tready),
        .frame_done(frame_done), .frame_err(frame_err)
    );

    always #CLK_HALF clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        if (frame_done) done_cnt++;
        if (frame_err) err_cnt++;
    end

    // Monitor: every bit the master samples with miso_oe high must match the next queued bit.
    always @(posedge sck) begin
        if (miso_oe) begin
            if (exp_q.size() == 0) chk("miso_unexpected", {31'd0, miso_oe}, 32'd0);
            else chk("miso_bit", {31'd0, miso}, {31'd0, exp_q.pop_front()});
        end
    end

    task automatic sck_cycle(input logic m);
        mosi = m;
        #SCK_HALF sck = 1'b1;
        #SCK_HALF sck = 1'b0;
    endtask

    task automatic axis_write(input logic ch, input logic [11:0] code);
        @(negedge clk);
        tdata  = {3'b101, ch, code};
        tvalid = 1'b1;
        @(negedge clk);
        tvalid = 1'b0;
    endtask

    // abort: 0 = full frame, 1 = cs raised after ndata bits, 2 = rst_n pulsed after ndata bits
    task automatic run_frame(input int lz, input logic sgl, input logic odd, input logic msbf,
                             input logic [11:0] code, input int abort, input int ndata,
                             input logic snap_wr, input logic [11:0] snap_code);
        int nbits, d0, e0;
        nbits = 0;
        d0 = done_cnt;
        e0 = err_cnt;
        exp_q.push_back(1'b0);
        for (int i = 11; i >= 0; i--) if (abort == 0 || nbits < ndata) begin
            exp_q.push_back(code[i]);
            nbits++;
        end
        if (abort == 0 && !msbf) for (int i = 1; i <= 11; i++) begin
            exp_q.push_back(code[i]);
            nbits++;
        end
        cs = 1'b0;
        #SCK_HALF;
        for (int i = 0; i < lz; i++) sck_cycle(1'b0);
        sck_cycle(1'b1);
        sck_cycle(sgl);
        sck_cycle(odd);
        if (snap_wr) axis_write(1'b0, snap_code);
        sck_cycle(msbf);
        for (int i = 0; i < 1 + nbits; i++) sck_cycle(1'b0);
        if (abort == 2) begin
            rst_n = 1'b0;
            #1;
            chk("rst_miso", {31'd0, miso}, 32'd0);
            chk("rst_oe", {31'd0, miso_oe}, 32'd0);
            chk("rst_tready", {31'd0, tready}, 32'd0);
            chk("rst_done_err", {30'd0, frame_done, frame_err}, 32'd0);
            cs = 1'b1;
            #20 rst_n = 1'b1;
            #(20 * CLK_HALF);
        end else if (abort == 1) begin
            cs = 1'b1;
            #(20 * CLK_HALF);
            chk("abort_oe", {31'd0, miso_oe}, 32'd0);
        end else begin
            sck_cycle(1'b0);
            #(20 * CLK_HALF);
            chk("end_oe", {31'd0, miso_oe}, 32'd0);
            cs = 1'b1;
            #(20 * CLK_HALF);
        end
        chk("frame_done_pulses", done_cnt - d0, (abort == 0) ? 32'd1 : 32'd0);
        chk("frame_err_pulses", err_cnt - e0, (abort == 1) ? 32'd1 : 32'd0);
        chk("bits_left", exp_q.size(), 32'd0);
        exp_q.delete();
    endtask

    initial begin
        rst_n = 1'b0; cs = 1'b1; sck = 1'b0; mosi = 1'b0; tdata = '0; tvalid = 1'b0;
        #23;
        chk("reset_outputs", {27'd0, miso, miso_oe, tready, frame_done, frame_err}, 32'd0);
        rst_n = 1'b1;
        #50;
        chk("tready_after_reset", {31'd0, tready}, 32'd1);
        axis_write(1'b0, 12'hABC);
        run_frame(0, 1, 0, 1, 12'hABC, 0, 0, 0, 12'h0);
        axis_write(1'b0, 12'h800);
        axis_write(1'b1, 12'h300);
        run_frame(0, 0, 0, 1, 12'h500, 0, 0, 0, 12'h0);
        run_frame(0, 0, 1, 1, 12'h000, 0, 0, 0, 12'h0);
        axis_write(1'b1, 12'h0F1);
        run_frame(0, 1, 1, 0, 12'h0F1, 0, 0, 0, 12'h0);
        run_frame(3, 1, 0, 1, 12'h800, 0, 0, 1, 12'hFFF);
        run_frame(0, 1, 0, 1, 12'hFFF, 0, 0, 0, 12'h0);
        run_frame(0, 1, 1, 1, 12'h0F1, 1, 5, 0, 12'h0);
        run_frame(0, 1, 1, 1, 12'h0F1, 0, 0, 0, 12'h0);
        run_frame(0, 1, 0, 1, 12'hFFF, 2, 3, 0, 12'h0);
        run_frame(0, 1, 0, 1, 12'h000, 0, 0, 0, 12'h0);
        run_frame(0, 1, 1, 0, 12'h000, 0, 0, 0, 12'h0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
